// File: rtl/mcse_btu_pkg.sv
// Shared types and AHB-Lite encodings for the MCSE bus translation unit.
package mcse_btu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_BURST = 3'd2,
    ST_LAST  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  function automatic int btu_beats(input int payload_bits, input int data_bits);
    return payload_bits / data_bits;
  endfunction

endpackage

// File: rtl/mcse_bus_translation_unit.sv
// Boot-control bus responder: turns one 128-bit request into a single AHB-Lite
// INCR4 burst and reports completion, read data and error status.
module mcse_bus_translation_unit
  import mcse_btu_pkg::*;
#(
  parameter int pAHB_ADDR_WIDTH    = 32,
  parameter int pAHB_DATA_WIDTH    = 32,
  parameter int pPAYLOAD_SIZE_BITS = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bootControl_bus_go,
  input  logic [pAHB_ADDR_WIDTH-1:0]    bootControl_bus_addr,
  input  logic [pPAYLOAD_SIZE_BITS-1:0] bootControl_bus_write,
  input  logic                          bootControl_bus_RW,
  output logic                          bootControl_bus_done,
  output logic [pPAYLOAD_SIZE_BITS-1:0] bootControl_bus_rdData,
  output logic                          bootControl_bus_err,
  output logic [pAHB_ADDR_WIDTH-1:0]    HADDR,
  output logic [1:0]                    HTRANS,
  output logic                          HWRITE,
  output logic [2:0]                    HSIZE,
  output logic [2:0]                    HBURST,
  output logic [pAHB_DATA_WIDTH-1:0]    HWDATA,
  input  logic [pAHB_DATA_WIDTH-1:0]    HRDATA,
  input  logic                          HREADY,
  input  logic                          HRESP
);

  localparam int AW    = pAHB_ADDR_WIDTH;
  localparam int DW    = pAHB_DATA_WIDTH;
  localparam int PS    = pPAYLOAD_SIZE_BITS;
  localparam int BEATS = btu_beats(PS, DW);
  localparam int CW    = $clog2(BEATS);
  localparam int BSH   = $clog2(DW / 8);
  // Aligning to the payload size keeps the whole burst inside one 1 KB page.
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(PS / 8 - 1);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(BEATS - 1);

  state_t          r_state;
  logic [AW-1:0]   r_base;
  logic [PS-1:0]   r_payload;
  logic            r_rw;
  logic [CW-1:0]   r_acnt;
  logic [CW-1:0]   r_dcnt;
  logic [AW-1:0]   r_haddr;
  logic [1:0]      r_htrans;
  logic            r_hwrite;
  logic [DW-1:0]   r_hwdata;
  logic            r_done;
  logic            r_err;
  logic [PS-1:0]   r_rdata;

  logic [CW-1:0]   w_anext;
  logic [CW-1:0]   w_dnext;
  logic [AW-1:0]   w_beat_addr;
  logic [DW-1:0]   w_wbeat_next;
  logic            w_rd_ok;
  logic            w_err1;
  logic            w_capture;

  assign w_anext      = r_acnt + 1'b1;
  assign w_dnext      = r_dcnt + 1'b1;
  assign w_beat_addr  = r_base + (AW'(w_anext) << BSH);
  assign w_wbeat_next = r_rw ? r_payload[w_dnext*DW +: DW] : '0;
  assign w_rd_ok      = HREADY & (HRESP == HRESP_OKAY);
  // First cycle of the two-cycle AHB error response.
  assign w_err1       = (HRESP == HRESP_ERROR) & ~HREADY;
  assign w_capture    = ~r_rw & w_rd_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_base    <= '0;
      r_payload <= '0;
      r_rw      <= 1'b0;
      r_acnt    <= '0;
      r_dcnt    <= '0;
      r_haddr   <= '0;
      r_htrans  <= HTRANS_IDLE;
      r_hwrite  <= 1'b0;
      r_hwdata  <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bootControl_bus_go) begin
            r_base    <= bootControl_bus_addr & ALIGN_MASK;
            r_haddr   <= bootControl_bus_addr & ALIGN_MASK;
            r_payload <= bootControl_bus_write;
            r_rw      <= bootControl_bus_RW;
            r_hwrite  <= bootControl_bus_RW;
            r_htrans  <= HTRANS_NONSEQ;
            r_acnt    <= '0;
            r_dcnt    <= '0;
            if (!bootControl_bus_RW) r_rdata <= '0;
            r_state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            r_htrans <= HTRANS_SEQ;
            r_haddr  <= w_beat_addr;
            r_acnt   <= w_anext;
            r_hwdata <= r_rw ? r_payload[DW-1:0] : '0;
            r_state  <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_err1) begin
            r_htrans <= HTRANS_IDLE;
            r_state  <= ST_ERR;
          end else if (HREADY) begin
            if (w_capture) r_rdata[r_dcnt*DW +: DW] <= HRDATA;
            r_dcnt   <= w_dnext;
            r_hwdata <= w_wbeat_next;
            if (r_acnt == LAST_BEAT) begin
              r_htrans <= HTRANS_IDLE;
              r_state  <= ST_LAST;
            end else begin
              r_haddr <= w_beat_addr;
              r_acnt  <= w_anext;
            end
          end
        end
        ST_LAST: begin
          if (w_err1) begin
            r_state <= ST_ERR;
          end else if (HREADY) begin
            if (w_capture) r_rdata[r_dcnt*DW +: DW] <= HRDATA;
            r_hwdata <= '0;
            r_hwrite <= 1'b0;
            r_acnt   <= '0;
            r_dcnt   <= '0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_ERR: begin
          if (HREADY) begin
            r_hwdata <= '0;
            r_hwrite <= 1'b0;
            r_acnt   <= '0;
            r_dcnt   <= '0;
            r_done   <= 1'b1;
            r_err    <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bootControl_bus_done   = r_done;
  assign bootControl_bus_err    = r_err;
  assign bootControl_bus_rdData = r_rdata;
  assign HADDR  = r_haddr;
  assign HTRANS = r_htrans;
  assign HWRITE = r_hwrite;
  assign HWDATA = r_hwdata;
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_INCR4;

endmodule

// File: tb/tb_mcse_bus_translation_unit.sv
// Directed bench for mcse_bus_translation_unit: writes, reads, wait states,
// error response, address alignment, ignored go and reset mid-burst.
module tb_mcse_bus_translation_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         go;
  logic [31:0]  addr;
  logic [127:0] wdat;
  logic         rw;
  logic         done;
  logic [127:0] rdData;
  logic         err;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic [2:0]   HSIZE;
  logic [2:0]   HBURST;
  logic [31:0]  HWDATA;
  logic [31:0]  HRDATA;
  logic         HREADY;
  logic         HRESP;

  int checks = 0;
  int errors = 0;

  logic [8:0]  hr;
  logic [1:0]  et [9];
  logic [31:0] ea [9];
  logic [31:0] ed [9];

  mcse_bus_translation_unit dut (
    .clk(clk), .rst(rst),
    .bootControl_bus_go(go), .bootControl_bus_addr(addr),
    .bootControl_bus_write(wdat), .bootControl_bus_RW(rw),
    .bootControl_bus_done(done), .bootControl_bus_rdData(rdData),
    .bootControl_bus_err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write burst driven from the et/ea/ed/hr tables; done expected at cycle n+1.
  task automatic run_write(input string tag, input logic [31:0] a, input logic [127:0] pl, input int n);
    go = 1'b1; addr = a; wdat = pl; rw = 1'b1;
    cyc();
    go = 1'b0;
    for (int c = 0; c < n; c++) begin
      chk($sformatf("%s_htrans_c%0d", tag, c + 1), {126'd0, HTRANS}, {126'd0, et[c]});
      chk($sformatf("%s_haddr_c%0d", tag, c + 1), {96'd0, HADDR}, {96'd0, ea[c]});
      chk($sformatf("%s_hwdata_c%0d", tag, c + 1), {96'd0, HWDATA}, {96'd0, ed[c]});
      if (c == 0) chk({tag, "_hwrite"}, {127'd0, HWRITE}, 128'd1);
      chk($sformatf("%s_nodone_c%0d", tag, c + 1), {127'd0, done}, 128'd0);
      HREADY = hr[c];
      cyc();
    end
    HREADY = 1'b1;
    chk({tag, "_done"}, {127'd0, done}, 128'd1);
    chk({tag, "_err"}, {127'd0, err}, 128'd0);
    cyc();
    chk({tag, "_done_pulse"}, {127'd0, done}, 128'd0);
  endtask

  // Zero-wait read; optional stray go injected mid-burst must be ignored.
  task automatic run_read(input string tag, input logic [31:0] a, input logic [31:0] base,
                          input logic [127:0] rd, input bit inj_go);
    go = 1'b1; addr = a; wdat = '0; rw = 1'b0;
    cyc();
    go = 1'b0;
    chk({tag, "_nonseq"}, {126'd0, HTRANS}, 128'd2);
    chk({tag, "_haddr0"}, {96'd0, HADDR}, {96'd0, base});
    chk({tag, "_hwrite"}, {127'd0, HWRITE}, 128'd0);
    chk({tag, "_rd_clear"}, rdData, 128'd0);
    for (int c = 2; c <= 5; c++) begin
      cyc();
      go = 1'b0;
      if (c < 5) begin
        chk($sformatf("%s_seq_c%0d", tag, c), {126'd0, HTRANS}, 128'd3);
        chk($sformatf("%s_haddr_c%0d", tag, c), {96'd0, HADDR}, {96'd0, base + 32'(4 * (c - 1))});
      end else begin
        chk({tag, "_idle_c5"}, {126'd0, HTRANS}, 128'd0);
      end
      if (inj_go && c == 3) begin
        go = 1'b1; addr = 32'h0000_9990; rw = 1'b1;
      end
      HRDATA = rd[32*(c-2) +: 32];
    end
    cyc();
    chk({tag, "_done"}, {127'd0, done}, 128'd1);
    chk({tag, "_err"}, {127'd0, err}, 128'd0);
    chk({tag, "_rdata"}, rdData, rd);
    cyc();
    chk({tag, "_done_pulse"}, {127'd0, done}, 128'd0);
    cyc();
    chk({tag, "_no_extra_done"}, {127'd0, done}, 128'd0);
    chk({tag, "_no_restart"}, {126'd0, HTRANS}, 128'd0);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; addr = '0; wdat = '0; rw = 1'b0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    #3;
    chk("rst_htrans", {126'd0, HTRANS}, 128'd0);
    chk("rst_haddr", {96'd0, HADDR}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_err", {127'd0, err}, 128'd0);
    chk("rst_rdata", rdData, 128'd0);
    chk("const_hsize", {125'd0, HSIZE}, 128'd2);
    chk("const_hburst", {125'd0, HBURST}, 128'd3);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Zero-wait write
    hr = 9'h1FF;
    et = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    ea = '{32'h4000_0010, 32'h4000_0014, 32'h4000_0018, 32'h4000_001C, 32'h4000_001C, 0, 0, 0, 0};
    ed = '{32'h0, 32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h0D0C_0B0A, 0, 0, 0, 0};
    run_write("wr0", 32'h4000_0010, 128'h0D0C0B0A_0C0B0A09_08070605_04030201, 5);

    // Unaligned read with a stray go mid-burst
    run_read("rd0", 32'h0000_1007, 32'h0000_1000,
             {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1);

    // Write with wait states: 2 on beat 1 data, 1 on beat 3 data
    hr = 9'b1_1011_0011;
    et = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
    ea = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008, 32'h300C, 32'h300C, 32'h300C, 0};
    ed = '{32'h0, 32'hA0A0_0000, 32'hA1A1_1111, 32'hA1A1_1111, 32'hA1A1_1111,
           32'hA2A2_2222, 32'hA3A3_3333, 32'hA3A3_3333, 0};
    run_write("wrw", 32'h0000_3000, 128'hA3A3_3333_A2A2_2222_A1A1_1111_A0A0_0000, 8);

    // Read with ERROR response on beat 2
    go = 1'b1; addr = 32'h5000; rw = 1'b0;
    cyc();
    go = 1'b0;
    chk("er_nonseq", {126'd0, HTRANS}, 128'd2);
    chk("er_rd_clear", rdData, 128'd0);
    cyc();
    HRDATA = 32'hA1;
    cyc();
    HRDATA = 32'hA2;
    cyc();
    chk("er_seq_c4", {126'd0, HTRANS}, 128'd3);
    HRDATA = 32'hDEAD; HRESP = 1'b1; HREADY = 1'b0;
    cyc();
    chk("er_idle_c5", {126'd0, HTRANS}, 128'd0);
    chk("er_nodone_c5", {127'd0, done}, 128'd0);
    HREADY = 1'b1;
    cyc();
    HRESP = 1'b0;
    chk("er_done", {127'd0, done}, 128'd1);
    chk("er_err", {127'd0, err}, 128'd1);
    chk("er_rdata", rdData, {32'h0, 32'h0, 32'hA2, 32'hA1});
    chk("er_idle_c6", {126'd0, HTRANS}, 128'd0);
    cyc();
    chk("er_done_pulse", {127'd0, done}, 128'd0);
    chk("er_err_clear", {127'd0, err}, 128'd0);
    chk("er_idle_c7", {126'd0, HTRANS}, 128'd0);

    // Reset in the middle of a write burst
    go = 1'b1; addr = 32'h6000; wdat = 128'h1; rw = 1'b1;
    cyc();
    go = 1'b0;
    cyc(); cyc();
    chk("rm_seq_before", {126'd0, HTRANS}, 128'd3);
    rst = 1'b1;
    #1;
    chk("rm_htrans", {126'd0, HTRANS}, 128'd0);
    chk("rm_haddr", {96'd0, HADDR}, 128'd0);
    chk("rm_hwrite", {127'd0, HWRITE}, 128'd0);
    chk("rm_hwdata", {96'd0, HWDATA}, 128'd0);
    chk("rm_rdata", rdData, 128'd0);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk($sformatf("rm_nodone_%0d", c), {127'd0, done}, 128'd0);
    end
    run_read("rd1", 32'h0000_7000, 32'h0000_7000,
             {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
